mc14500_wide_icu: RTL

//  W-bit, program-counter-equipped successor to the 1-bit MC14500B ICU core.

---
 rtl/mc14500_wide_icu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mc14500_wide_icu.sv
// mc14500_wide_icu: W-bit MC14500B-style ICU with PC, per-bit IEN/OEN masks, skip unit and a
// JMP/RTN call stack built only when ICU_CALL_STACK_EN is defined. One instruction per clk, all
// outputs registered (visible the cycle after issue). No backpressure: ROM and I/O bus always ready.
module mc14500_wide_icu #(
  parameter int W      = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        i,
  input  logic [W-1:0]      data_in,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [W-1:0]      rr_out,
  output logic [W-1:0]      data_out,
  output logic              write,
  output logic              jmp,
  output logic              rtn,
  output logic              flag_o,
  output logic              flag_f,
  output logic              stk_ovf,
  output logic              stk_unf
);

  typedef enum logic [3:0] {
    NOPO = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND  = 4'h3,
    ANDC = 4'h4, OR   = 4'h5, ORC  = 4'h6, XNOR = 4'h7,
    STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
    JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
  } instr_t;

  instr_t            op;
  logic [W-1:0]      ien;
  logic [W-1:0]      oen;
  logic [W-1:0]      din;
  logic              skip;
  logic              exec;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] rtn_pc;

  assign op     = instr_t'(i);
  assign din    = data_in & ien;
  assign exec   = !skip;
  assign pc_inc = pc + ADDR_W'(1);

`ifdef ICU_CALL_STACK_EN
  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] FULL = SP_W'(DEPTH);

  logic [ADDR_W-1:0] stk [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_m1;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full  = (sp == FULL);
  assign empty = (sp == '0);
  assign sp_m1 = sp - SP_W'(1);
  assign push  = exec && (op == JMP) && !full;
  assign pop   = exec && (op == RTN) && !empty;

  // Return addresses need no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) stk[sp[IW-1:0]] <= pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp      <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp_m1;
      if (exec && (op == JMP) && full)  stk_ovf <= 1'b1;
      if (exec && (op == RTN) && empty) stk_unf <= 1'b1;
    end
  end

  assign rtn_pc = pop ? stk[sp_m1[IW-1:0]] : pc_inc;
`else
  logic unused_depth;
  assign unused_depth = (DEPTH >= 1);
  assign rtn_pc  = pc_inc;
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      rr_out   <= '0;
      data_out <= '0;
      ien      <= '0;
      oen      <= '0;
      skip     <= 1'b0;
      write    <= 1'b0;
      jmp      <= 1'b0;
      rtn      <= 1'b0;
      flag_o   <= 1'b0;
      flag_f   <= 1'b0;
    end else begin
      write  <= 1'b0;
      jmp    <= 1'b0;
      rtn    <= 1'b0;
      flag_o <= 1'b0;
      flag_f <= 1'b0;
      pc     <= pc_inc;
      // A suppressed instruction only consumes the skip; it never re-arms it.
      if (skip) begin
        skip <= 1'b0;
      end else begin
        case (op)
          NOPO: flag_o <= 1'b1;
          LD:   rr_out <= din;
          LDC:  rr_out <= ~din;
          AND:  rr_out <= rr_out & din;
          ANDC: rr_out <= rr_out & ~din;
          OR:   rr_out <= rr_out | din;
          ORC:  rr_out <= rr_out | ~din;
          XNOR: rr_out <= ~(rr_out ^ din);
          STO: begin
            data_out <= (rr_out & oen) | (data_out & ~oen);
            write    <= |oen;
          end
          STOC: begin
            data_out <= (~rr_out & oen) | (data_out & ~oen);
            write    <= |oen;
          end
          IEN:  ien <= data_in;
          OEN:  oen <= data_in;
          JMP: begin
            pc  <= jmp_addr;
            jmp <= 1'b1;
          end
          RTN: begin
            pc   <= rtn_pc;
            rtn  <= 1'b1;
            skip <= 1'b1;
          end
          SKZ:  skip <= (rr_out == '0);
          NOPF: flag_f <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
